// File: rtl/buffer_drain_unit.sv
// Streams every word of a buffer RAM, in address order, onto a valid/ready port.
// Reads are credit-limited against an output FIFO; optional macro DRAIN_ZERO_FILL_EN zeroes the RAM behind the reads.
module buffer_drain_unit #(
  parameter int WIDTH        = 10,
  parameter int DATA_W       = 512,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_drain,
  output logic              drain_working,
  output logic              drain_done,
  output logic [WIDTH-1:0]  ram_raddr,
  output logic              ram_rden,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [WIDTH-1:0]  out_idx,
  output logic              out_last
`ifdef DRAIN_ZERO_FILL_EN
  ,
  output logic              ram_wren,
  output logic [WIDTH-1:0]  ram_waddr,
  output logic [DATA_W-1:0] ram_wdata
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, FLUSH} state_e;

  typedef struct packed {
    logic             vld;
    logic             last;
    logic [WIDTH-1:0] addr;
  } tag_t;

  typedef struct packed {
    logic              last;
    logic [WIDTH-1:0]  idx;
    logic [DATA_W-1:0] data;
  } ent_t;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]    credits_q, credits_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             last_acc_q, last_acc_d;
  tag_t             pipe_q [READ_LATENCY];
  tag_t             pipe_d [READ_LATENCY];
  ent_t             fifo_q [FIFO_DEPTH];

  tag_t tail;
  logic issue, fifo_empty, pipe_busy, hs, push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign tail          = pipe_q[READ_LATENCY-1];
  assign fifo_empty    = (count_q == '0);
  assign drain_working = (state_q != IDLE);
  assign ram_rden      = issue;
  assign ram_raddr     = issue ? rd_cnt_q : '0;

  // FIFO head falls through; an emerging read bypasses an empty FIFO so the
  // first word shows up in the same cycle its RAM data does.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_idx   = '0;
    out_last  = 1'b0;
    if (!fifo_empty) begin
      out_valid = 1'b1;
      out_data  = fifo_q[rd_ptr_q].data;
      out_idx   = fifo_q[rd_ptr_q].idx;
      out_last  = fifo_q[rd_ptr_q].last;
    end else if (tail.vld) begin
      out_valid = 1'b1;
      out_data  = ram_rdata;
      out_idx   = tail.addr;
      out_last  = tail.last;
    end
  end

  assign hs   = out_valid && out_ready;
  assign pop  = hs && !fifo_empty;
  assign push = tail.vld && !(fifo_empty && out_ready);

  always_comb begin
    pipe_busy = 1'b0;
    for (int i = 0; i < READ_LATENCY; i++) pipe_busy = pipe_busy | pipe_q[i].vld;
  end

  always_comb begin
    state_d    = state_q;
    rd_cnt_d   = rd_cnt_q;
    issue      = 1'b0;
    drain_done = 1'b0;
    last_acc_d = last_acc_q | (hs && out_last);
    case (state_q)
      IDLE: begin
        if (start_drain) begin
          state_d    = ISSUE;
          rd_cnt_d   = '0;
          last_acc_d = 1'b0;
        end
      end
      ISSUE: begin
        if (credits_q != '0) begin
          issue = 1'b1;
          if (rd_cnt_q == {WIDTH{1'b1}}) state_d = FLUSH;
          else                           rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      FLUSH: begin
        if (fifo_empty && !pipe_busy && last_acc_q) begin
          drain_done = 1'b1;
          last_acc_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Credits count free FIFO slots not yet claimed by in-flight reads.
  always_comb begin
    credits_d = credits_q + CW'(hs) - CW'(issue);
    count_d   = count_q + CW'(push) - CW'(pop);
    wr_ptr_d  = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d  = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    pipe_d[0].vld  = issue;
    pipe_d[0].last = (rd_cnt_q == {WIDTH{1'b1}});
    pipe_d[0].addr = rd_cnt_q;
    for (int i = 1; i < READ_LATENCY; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_cnt_q   <= '0;
      credits_q  <= CW'(FIFO_DEPTH);
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      last_acc_q <= 1'b0;
      for (int i = 0; i < READ_LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      rd_cnt_q   <= rd_cnt_d;
      credits_q  <= credits_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      last_acc_q <= last_acc_d;
      for (int i = 0; i < READ_LATENCY; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  // Storage needs no reset: an entry is only visible while count_q covers it.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= '{last: tail.last, idx: tail.addr, data: ram_rdata};
  end

`ifdef DRAIN_ZERO_FILL_EN
  // The write trails the read of the same address, so no hazard.
  assign ram_wren  = tail.vld;
  assign ram_waddr = tail.addr;
  assign ram_wdata = '0;
`endif

endmodule

// File: tb/tb_buffer_drain_unit.sv
// Randomised/self-checking bench for buffer_drain_unit with a behavioural RAM
// and a stream-level reference model (expected words, credit bound, drain timing).
module tb_buffer_drain_unit;
  localparam int WIDTH  = 4;
  localparam int DATA_W = 32;
  localparam int LAT    = 2;
  localparam int DEPTH  = 4;
  localparam int N      = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start_drain = 1'b0;
  logic              out_ready = 1'b0;
  logic              drain_working, drain_done, ram_rden, out_valid, out_last;
  logic [WIDTH-1:0]  ram_raddr, out_idx;
  logic [DATA_W-1:0] ram_rdata, out_data;
`ifdef DRAIN_ZERO_FILL_EN
  logic              ram_wren;
  logic [WIDTH-1:0]  ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
`endif

  buffer_drain_unit #(.WIDTH(WIDTH), .DATA_W(DATA_W), .READ_LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start_drain(start_drain),
    .drain_working(drain_working), .drain_done(drain_done),
    .ram_raddr(ram_raddr), .ram_rden(ram_rden), .ram_rdata(ram_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last)
`ifdef DRAIN_ZERO_FILL_EN
    , .ram_wren(ram_wren), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural RAM: data appears LAT cycles after the read request.
  logic [DATA_W-1:0] mem   [N];
  logic [DATA_W-1:0] rpipe [LAT];
  logic              preload_req = 1'b0;
  always @(posedge clk) begin
    rpipe[0] <= ram_rden ? mem[ram_raddr] : '0;
    for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
    if (preload_req) for (int i = 0; i < N; i++) mem[i] <= DATA_W'(3 * i + 1);
`ifdef DRAIN_ZERO_FILL_EN
    else if (ram_wren) mem[ram_waddr] <= ram_wdata;
`endif
  end
  assign ram_rdata = rpipe[LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;
  int test_id = 0, ready_mode = 0;
  int busy_m = 0, start_cyc = 0, issued = 0, accepted = 0, exp_idx = 0, wr_seen = 0;
  int last_hs_cyc = 0, done_cnt = 0, first_valid_rel = -1;
  logic [DATA_W-1:0] first_data, last_data, prev_data;
  logic [WIDTH-1:0]  prev_idx;
  logic              prev_last, prev_stall = 1'b0, post_rst = 1'b0;
  logic [DATA_W-1:0] model_mem [N];
  logic [DATA_W-1:0] snap      [N];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Consumer: ready pattern chosen per test, relative to the accepted start.
  initial forever begin
    int rel;
    @(posedge clk); #1;
    rel = cyc - start_cyc;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = (rel % 4 == 0) || (rel % 4 == 3);
      2: out_ready = (rel >= 20);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Reference model and every-cycle compare.
  always @(negedge clk) begin
    if (preload_req) for (int i = 0; i < N; i++) model_mem[i] = DATA_W'(3 * i + 1);
    if (rst) begin
      busy_m = 0; post_rst = 1'b1; prev_stall = 1'b0;
    end else begin
      if (post_rst) begin
        chk("reset_outputs", {drain_working, drain_done, ram_rden, ram_raddr, out_valid,
                              out_data, out_idx, out_last}, '0);
`ifdef DRAIN_ZERO_FILL_EN
        chk("reset_wr_outputs", {ram_wren, ram_waddr}, '0);
`endif
        post_rst = 1'b0;
      end
      chk("working", drain_working, 64'(busy_m != 0));
      if (busy_m == 0) begin
        chk("idle_quiet", {out_valid, ram_rden, drain_done}, '0);
`ifdef DRAIN_ZERO_FILL_EN
        chk("idle_no_write", ram_wren, '0);
`endif
      end else begin
        if (ram_rden) begin
          chk("credit_limit", 64'((issued - accepted) < DEPTH), 1);
          chk("raddr_order", ram_raddr, 64'(issued));
          issued++;
        end
        if (prev_stall)
          chk("hold_stable", {out_valid, out_last, out_idx, out_data},
                             {1'b1, prev_last, prev_idx, prev_data});
        if (out_valid && first_valid_rel < 0) first_valid_rel = cyc - start_cyc;
        if (out_valid && out_ready) begin
          chk("word_count_bound", 64'(exp_idx < N), 1);
          if (exp_idx < N)
            chk("out_word", {out_last, out_idx, out_data},
                            {exp_idx == N - 1, WIDTH'(exp_idx), snap[exp_idx]});
          if (exp_idx == 0) first_data = out_data;
          last_data = out_data;
          exp_idx++; accepted++; last_hs_cyc = cyc;
        end
`ifdef DRAIN_ZERO_FILL_EN
        if (ram_wren) begin
          chk("zero_write", {ram_waddr, ram_wdata}, {WIDTH'(wr_seen), {DATA_W{1'b0}}});
          wr_seen++;
        end
`endif
        if (test_id == 3 && cyc - start_cyc == 19) begin
          chk("stall_reads", 64'(issued), 4);
          chk("stall_head", {out_valid, out_data}, {1'b1, 32'd1});
        end
        if (cyc - start_cyc == 600) chk("drain_timeout", 64'(exp_idx), N + 1000);
        if (drain_done) begin
          done_cnt++;
          chk("done_all_words", 64'(exp_idx), N);
          chk("done_after_last", 64'(cyc - last_hs_cyc), 1);
          if (test_id == 1) begin
            chk("ff_first_valid", 64'(first_valid_rel), 3);
            chk("ff_done_cycle", 64'(cyc - start_cyc), 19);
            chk("ff_first_word", first_data, 1);
            chk("ff_last_word", last_data, 46);
          end
`ifdef DRAIN_ZERO_FILL_EN
          begin
            logic allz;
            allz = 1'b1;
            for (int i = 0; i < N; i++) if (mem[i] !== '0) allz = 1'b0;
            chk("wren_count", 64'(wr_seen), N);
            chk("mem_zeroed", allz, 1);
            for (int i = 0; i < N; i++) model_mem[i] = '0;
          end
`endif
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_idx   = out_idx;
      prev_last  = out_last;
      if (start_drain && busy_m == 0) begin
        busy_m = 1; start_cyc = cyc; issued = 0; accepted = 0; exp_idx = 0;
        wr_seen = 0; first_valid_rel = -1;
        for (int i = 0; i < N; i++) snap[i] = model_mem[i];
      end
      if (drain_done) busy_m = 0;
    end
  end

  task automatic run_drain(input int tid, input int mode, input int extra_start,
                           input int rst_at, input bit preload);
    int d0;
    @(posedge clk); #1;
    test_id = tid; ready_mode = mode;
    if (preload) begin
      preload_req = 1'b1;
      @(posedge clk); #1;
      preload_req = 1'b0;
    end
    start_drain = 1'b1;
    d0 = done_cnt;
    for (int k = 1; k < 700; k++) begin
      @(posedge clk); #1;
      start_drain = (k == extra_start);
      rst         = (k == rst_at);
      if (rst_at < 0 && done_cnt != d0) break;
      if (rst_at >= 0 && k >= rst_at + 4) break;
    end
    start_drain = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    run_drain(1, 0, -1, -1, 1'b1);  // free flow
    run_drain(2, 1, -1, -1, 1'b1);  // 1,0,0,1 backpressure
    run_drain(3, 2, -1, -1, 1'b1);  // stalled for 20 cycles
    run_drain(4, 0,  5, -1, 1'b1);  // start while busy
    run_drain(5, 0, -1,  8, 1'b1);  // reset mid-drain
    run_drain(6, 0, -1, -1, 1'b1);  // fresh drain after reset
    run_drain(7, 3, -1, -1, 1'b1);  // random ready
    run_drain(8, 3, -1, -1, 1'b1);
`ifdef DRAIN_ZERO_FILL_EN
    run_drain(9, 0, -1, -1, 1'b0);  // buffer already zeroed
`endif
    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/buffer_drain_unit.md
Name: buffer_drain_unit

Overview:
Streaming reader for a buffer RAM, the opposite end of the set-uint copy path. On start it reads every word of one buffer RAM (addresses 0..2^WIDTH-1) and presents the words in order on a valid/ready output stream for the host/DMA side. RAM read latency is hidden with a credit-limited output FIFO, so the stream is gap-free when out_ready stays high and lossless under backpressure.

Parameters:
WIDTH, 10, buffer address bits; N_ITEMS = 2^WIDTH words per drain
DATA_W, 512, RAM word width (E*FSIZE in the top level)
READ_LATENCY, 2, cycles from ram_raddr/ram_rden to valid ram_rdata (BUFFER_READ_LATENCY)
FIFO_DEPTH, 4, output FIFO entries; must be >= READ_LATENCY+1

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start_drain  in  1  one-cycle start pulse
drain_working  out  1  high from the cycle after an accepted start until done
drain_done  out  1  one-cycle pulse after the last word is accepted
ram_raddr  out  WIDTH  read address
ram_rden  out  1  read enable, one read issued per high cycle
ram_rdata  in  DATA_W  read data, valid READ_LATENCY cycles after ram_rden
out_valid  out  1  stream word valid
out_ready  in  1  consumer ready
out_data  out  DATA_W  stream word
out_idx  out  WIDTH  RAM address of out_data
out_last  out  1  high with the word for address N_ITEMS-1

Behaviour:
- Reset: rst is synchronous and active-high, sampled on posedge clk. Reset clears state to IDLE, rd_cnt=0, in-flight pipe, FIFO, and credits. All outputs are 0 after reset.
- States: IDLE, ISSUE, FLUSH.
- IDLE + start_drain -> ISSUE, rd_cnt=0.
- ISSUE: ram_rden=1 and ram_raddr=rd_cnt when credits>0. Then rd_cnt increments and credits decrement in the same cycle.
- When the read at rd_cnt==N_ITEMS-1 issues: go to FLUSH. rd_cnt does not wrap or reissue.
- FLUSH: no reads. When the FIFO is empty, no reads are in flight, and the last word has been accepted, pulse drain_done for one cycle and go to IDLE.
- Credits: start at FIFO_DEPTH. Decrement on read issue, increment on out handshake (out_valid && out_ready). Both in one cycle leaves credits unchanged. Credits never exceed FIFO_DEPTH and never go below 0, so the FIFO can never overflow.
- In-flight pipe: a READ_LATENCY-deep shift of {valid, addr, last}. When a valid entry emerges, ram_rdata, addr and last are pushed into the FIFO in that cycle.
- Output: first-word-fall-through from the FIFO. out_* is held stable while out_valid && !out_ready.
- Latency: with out_ready=1 throughout, the first out_valid appears READ_LATENCY+1 cycles after the start cycle. Afterwards there is one word per cycle with no bubbles. drain_done comes 1 cycle after the last handshake.
- drain_working = (state != IDLE).
- start_drain while not IDLE is ignored.
- rst mid-drain: in-flight reads are discarded and no stale word appears after reset.
- Simultaneous FIFO push and pop on a full FIFO is legal; occupancy is unchanged.

Optional Feature:
Macro DRAIN_ZERO_FILL_EN.
- Defined: adds outputs ram_wren (1), ram_waddr (WIDTH) and ram_wdata (DATA_W, always 0). Each address is written to zero in the same cycle its read data leaves the in-flight pipe, so the buffer is all-zero once drain_done pulses. There is no read/write hazard because the write trails the read of that address.
- Undefined: these ports are absent and the RAM is never written.

Test Plan:
All scenarios use WIDTH=4, READ_LATENCY=2, FIFO_DEPTH=4, RAM preloaded mem[i]=3*i+1.
- Free-flow: start at cycle 0 with out_ready=1 -> out_valid first at cycle 3; 16 consecutive words 1,4,...,46 with out_idx 0..15; out_last only on idx 15; drain_done at cycle 19; drain_working high cycles 1..19.
- Backpressure: out_ready toggles 1,0,0,1 repeating -> same 16 words in order, none duplicated or dropped; ram_rden never issues when credits=0; FIFO occupancy never exceeds 4.
- Stall from start: out_ready=0 for 20 cycles, then 1 -> exactly 4 reads issued, out_data=1 held stable; the remaining 12 words stream after release; done pulses once.
- Start while busy: second start_drain at cycle 5 -> ignored; exactly 16 words and a single drain_done.
- Reset mid-drain: rst at cycle 8 -> all outputs 0 next cycle, no residual out_valid. A fresh start then delivers all 16 words from idx 0.
- DRAIN_ZERO_FILL_EN defined -> 16 ram_wren pulses with waddr 0..15 and wdata 0; mem all-zero at drain_done; a second drain outputs 16 zeros.
